// File: rtl/atm_vc_route_lookup_if.sv
// atm_vc_route_lookup_if: cell stream in/out, table config and
// miss counter signals of the VPI/VCI route lookup.
interface atm_vc_route_lookup_if #(
  parameter int CELL_W = 53,
  parameter int KEY_W  = 16,
  parameter int IDX_W  = 3,
  parameter int PORT_W = 2,
  parameter int CNT_W  = 16
);
  logic [CELL_W-1:0] cell_in;
  logic              cell_valid;
  logic              cell_ready;
  logic [CELL_W-1:0] out_cell;
  logic [PORT_W-1:0] out_port;
  logic              out_hit;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [KEY_W-1:0]  cfg_key;
  logic [PORT_W-1:0] cfg_port;
  logic              cfg_en;
  logic [CNT_W-1:0]  miss_count;
  logic              miss_clr;

  modport master (
    output cell_in, cell_valid, out_ready,
    output cfg_we, cfg_idx, cfg_key, cfg_port, cfg_en,
    output miss_clr,
    input  cell_ready, out_cell, out_port, out_hit,
    input  out_valid, miss_count
  );

  modport slave (
    input  cell_in, cell_valid, out_ready,
    input  cfg_we, cfg_idx, cfg_key, cfg_port, cfg_en,
    input  miss_clr,
    output cell_ready, out_cell, out_port, out_hit,
    output out_valid, miss_count
  );
endinterface

// File: rtl/atm_vc_route_lookup.sv
// atm_vc_route_lookup: VPI/VCI keyed route lookup against a
// programmable associative table, one registered output stage.
module atm_vc_route_lookup #(
  parameter int CELL_W       = 53,
  parameter int KEY_MSB      = 47,
  parameter int KEY_LSB      = 32,
  parameter int N_ENTRIES    = 8,
  parameter int PORT_W       = 2,
  parameter int DEFAULT_PORT = 0,
  parameter int DROP_ON_MISS = 0,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  atm_vc_route_lookup_if.slave bus
);
  localparam int KEY_W = KEY_MSB - KEY_LSB + 1;
  localparam int IDX_W =
    (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

  logic [KEY_W-1:0]     tkey  [N_ENTRIES];
  logic [PORT_W-1:0]    tport [N_ENTRIES];
  logic [N_ENTRIES-1:0] ten;

  logic [KEY_W-1:0]  key;
  logic              lk_hit;
  logic [PORT_W-1:0] lk_port;
  logic              accept;
  logic              load;

  assign key = bus.cell_in[KEY_MSB:KEY_LSB];

  // Out-of-range indices match no entry, so those writes vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ten <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        tkey[i]  <= '0;
        tport[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (bus.cfg_we && bus.cfg_idx == IDX_W'(i)) begin
          tkey[i]  <= bus.cfg_key;
          tport[i] <= bus.cfg_port;
          ten[i]   <= bus.cfg_en;
        end
      end
    end
  end

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_port = PORT_W'(DEFAULT_PORT);
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (ten[i] && tkey[i] == key) begin
        lk_hit  = 1'b1;
        lk_port = tport[i];
      end
    end
  end

  assign bus.cell_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.cell_valid && bus.cell_ready;
  assign load   = accept && (lk_hit || DROP_ON_MISS == 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_cell  <= '0;
      bus.out_port  <= '0;
      bus.out_hit   <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_cell  <= bus.cell_in;
      bus.out_port  <= lk_port;
      bus.out_hit   <= lk_hit;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.miss_count <= '0;
    end else if (bus.miss_clr) begin
      bus.miss_count <= '0;
    end else if (accept && !lk_hit &&
                 bus.miss_count != {CNT_W{1'b1}}) begin
      bus.miss_count <= bus.miss_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_atm_vc_route_lookup.sv
// tb_atm_vc_route_lookup: scoreboard bench; dut0 forwards misses,
// dut1 drops misses with 6 entries and a 4-bit counter.
module tb_atm_vc_route_lookup;
  typedef logic [55:0] exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t q0[$];
  exp_t q1[$];

  atm_vc_route_lookup_if #(.IDX_W(3), .CNT_W(16)) b0 ();
  atm_vc_route_lookup_if #(.IDX_W(3), .CNT_W(4))  b1 ();

  atm_vc_route_lookup dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  atm_vc_route_lookup #(
    .N_ENTRIES(6), .DROP_ON_MISS(1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && b0.out_valid && b0.out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL out0_unexpected got=%h", b0.out_cell);
      end else begin
        e = q0.pop_front();
        if ({b0.out_cell, b0.out_port, b0.out_hit} !== e) begin
          failures++;
          $display("FAIL out0_data got=%h exp=%h",
            {b0.out_cell, b0.out_port, b0.out_hit}, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && b1.out_valid && b1.out_ready) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL out1_unexpected got=%h", b1.out_cell);
      end else begin
        e = q1.pop_front();
        if ({b1.out_cell, b1.out_port, b1.out_hit} !== e) begin
          failures++;
          $display("FAIL out1_data got=%h exp=%h",
            {b1.out_cell, b1.out_port, b1.out_hit}, e);
        end
      end
    end
  end

  function automatic logic [52:0] mk(input logic [15:0] k);
    logic [52:0] c;
    c = 53'({$urandom, $urandom});
    c[47:32] = k;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg0(input logic [2:0] i, input logic [15:0] k,
                      input logic [1:0] p, input logic en);
    b0.cfg_we = 1; b0.cfg_idx = i; b0.cfg_key = k;
    b0.cfg_port = p; b0.cfg_en = en;
    tick();
    b0.cfg_we = 0;
  endtask

  task automatic cfg1(input logic [2:0] i, input logic [15:0] k,
                      input logic [1:0] p, input logic en);
    b1.cfg_we = 1; b1.cfg_idx = i; b1.cfg_key = k;
    b1.cfg_port = p; b1.cfg_en = en;
    tick();
    b1.cfg_we = 0;
  endtask

  task automatic send0(input logic [52:0] c,
                       input logic [1:0] p, input logic h);
    b0.cell_in = c; b0.cell_valid = 1;
    q0.push_back({c, p, h});
    tick();
    b0.cell_valid = 0;
  endtask

  task automatic send1(input logic [52:0] c, input logic [1:0] p,
                       input logic h, input logic fwd);
    b1.cell_in = c; b1.cell_valid = 1;
    if (fwd) q1.push_back({c, p, h});
    tick();
    b1.cell_valid = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({b0.out_valid, b0.out_cell, b0.out_port, b0.out_hit}
        !== '0) begin
      failures++;
      $display("FAIL reset_out0 got=%b/%h/%h/%b exp=0",
        b0.out_valid, b0.out_cell, b0.out_port, b0.out_hit);
    end
    checks++;
    if (b0.miss_count !== 16'd0 || b1.miss_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_miss got=%0d/%0d exp=0",
        b0.miss_count, b1.miss_count);
    end
    checks++;
    if (b0.cell_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b/%b exp=1/0",
        b0.cell_ready, b1.out_valid);
    end
  endtask

  task automatic test_hit();
    cfg0(3'd0, 16'h1001, 2'd1, 1'b1);
    send0(mk(16'h1001), 2'd1, 1'b1);
    checks++;
    if (b0.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL hit_latency got=%b exp=1", b0.out_valid);
    end
    tick();
  endtask

  task automatic test_miss();
    send0(mk(16'h2222), 2'd0, 1'b0);
    checks++;
    if (b0.miss_count !== 16'd1) begin
      failures++;
      $display("FAIL miss_cnt0 got=%0d exp=1", b0.miss_count);
    end
    send1(mk(16'h2222), 2'd0, 1'b0, 1'b0);
    checks++;
    if (b1.out_valid !== 1'b0 || b1.miss_count !== 4'd1) begin
      failures++;
      $display("FAIL miss_drop got=%b/%0d exp=0/1",
        b1.out_valid, b1.miss_count);
    end
    tick();
  endtask

  task automatic test_priority();
    cfg0(3'd2, 16'h1003, 2'd3, 1'b1);
    cfg0(3'd5, 16'h1003, 2'd2, 1'b1);
    send0(mk(16'h1003), 2'd3, 1'b1);
    cfg0(3'd2, 16'h1003, 2'd3, 1'b0);
    send0(mk(16'h1003), 2'd2, 1'b1);
    tick();
  endtask

  task automatic test_bad_idx();
    cfg1(3'd6, 16'h3333, 2'd1, 1'b1);
    cfg1(3'd7, 16'h3333, 2'd2, 1'b1);
    send1(mk(16'h3333), 2'd0, 1'b0, 1'b0);
    checks++;
    if (b1.out_valid !== 1'b0 || b1.miss_count !== 4'd2) begin
      failures++;
      $display("FAIL bad_idx got=%b/%0d exp=0/2",
        b1.out_valid, b1.miss_count);
    end
    cfg1(3'd5, 16'h3333, 2'd3, 1'b1);
    send1(mk(16'h3333), 2'd3, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [52:0] a;
    logic [52:0] b;
    a = mk(16'h1001);
    b = mk(16'h2222);
    b0.out_ready = 0;
    b0.cell_in = a; b0.cell_valid = 1;
    q0.push_back({a, 2'd1, 1'b1});
    tick();
    b0.cell_in = b;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b0.out_valid !== 1'b1 || b0.cell_ready !== 1'b0 ||
          b0.out_cell !== a || b0.out_port !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold got=%b/%b/%h exp=1/0/%h",
          b0.out_valid, b0.cell_ready, b0.out_cell, a);
      end
      tick();
    end
    b0.out_ready = 1;
    q0.push_back({b, 2'd0, 1'b0});
    tick();
    b0.cell_valid = 0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.out_cell !== b) begin
      failures++;
      $display("FAIL stall_release got=%b/%h exp=1/%h",
        b0.out_valid, b0.out_cell, b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] k [6];
    logic [1:0]  p [6];
    logic        h [6];
    k = '{16'h1001, 16'h2222, 16'h1003,
          16'h1001, 16'h2222, 16'h2222};
    p = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};
    h = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    b0.miss_clr = 1;
    tick();
    b0.miss_clr = 0;
    checks++;
    if (b0.miss_count !== 16'd0) begin
      failures++;
      $display("FAIL clr got=%0d exp=0", b0.miss_count);
    end
    for (int i = 0; i < 6; i++) begin
      b0.cell_in = mk(k[i]); b0.cell_valid = 1;
      q0.push_back({b0.cell_in, p[i], h[i]});
      tick();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.cell_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_bubble i=%0d got=%b/%b exp=1/1",
          i, b0.out_valid, b0.cell_ready);
      end
    end
    b0.cell_valid = 0;
    checks++;
    if (b0.miss_count !== 16'd3) begin
      failures++;
      $display("FAIL b2b_miss got=%0d exp=3", b0.miss_count);
    end
    tick();
  endtask

  task automatic test_write_same_cycle();
    b0.cfg_we = 1; b0.cfg_idx = 3'd0; b0.cfg_key = 16'h1004;
    b0.cfg_port = 2'd3; b0.cfg_en = 1;
    send0(mk(16'h1004), 2'd0, 1'b0);
    b0.cfg_we = 0;
    send0(mk(16'h1004), 2'd3, 1'b1);
    tick();
  endtask

  task automatic test_saturate();
    b1.miss_clr = 1;
    tick();
    b1.miss_clr = 0;
    b1.cell_valid = 1;
    for (int i = 0; i < 16; i++) begin
      b1.cell_in = mk(16'h2222);
      tick();
    end
    b1.cell_valid = 0;
    checks++;
    if (b1.miss_count !== 4'd15) begin
      failures++;
      $display("FAIL sat got=%0d exp=15", b1.miss_count);
    end
    b1.miss_clr = 1;
    send1(mk(16'h2222), 2'd0, 1'b0, 1'b0);
    b1.miss_clr = 0;
    checks++;
    if (b1.miss_count !== 4'd0) begin
      failures++;
      $display("FAIL clr_prio got=%0d exp=0", b1.miss_count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    b0.out_ready = 0;
    b0.cell_in = mk(16'h1004); b0.cell_valid = 1;
    tick();
    b0.cell_valid = 0;
    checks++;
    if (b0.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=1", b0.out_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (b0.out_valid !== 1'b0 || b0.out_cell !== '0 ||
        b0.miss_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_async got=%b/%h/%0d exp=0/0/0",
        b0.out_valid, b0.out_cell, b0.miss_count);
    end
    tick();
    rst = 0;
    b0.out_ready = 1;
    send0(mk(16'h1004), 2'd0, 1'b0);
    send0(mk(16'h1001), 2'd0, 1'b0);
    send1(mk(16'h3333), 2'd0, 1'b0, 1'b0);
    checks++;
    if (b1.out_valid !== 1'b0 || b1.miss_count !== 4'd1 ||
        b0.miss_count !== 16'd2) begin
      failures++;
      $display("FAIL rst_cleared got=%b/%0d/%0d exp=0/1/2",
        b1.out_valid, b1.miss_count, b0.miss_count);
    end
    tick();
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0",
        q0.size(), q1.size());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    b0.cell_in = '0; b0.cell_valid = 0; b0.out_ready = 1;
    b0.cfg_we = 0; b0.cfg_idx = '0; b0.cfg_key = '0;
    b0.cfg_port = '0; b0.cfg_en = 0; b0.miss_clr = 0;
    b1.cell_in = '0; b1.cell_valid = 0; b1.out_ready = 1;
    b1.cfg_we = 0; b1.cfg_idx = '0; b1.cfg_key = '0;
    b1.cfg_port = '0; b1.cfg_en = 0; b1.miss_clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_hit();
    test_miss();
    test_priority();
    test_bad_idx();
    test_backpressure();
    test_back_to_back();
    test_write_same_cycle();
    test_saturate();
    test_drain();
    test_reset_mid();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/atm_vc_route_lookup.md
Name: atm_vc_route_lookup

Overview:
Parametrised successor to the fixed VPI/VCI header router. It takes ATM cells on a valid/ready stream and matches the VPI/VCI key field against a runtime-programmable N-entry associative table. It emits the cell with its output port ID and hit flag through a one-stage registered output, and keeps a saturating miss counter. It sits between cell ingress and the switch fabric arbiter.

Parameters:
CELL_W, 53, cell width in bits
KEY_MSB, 47, MSB of the VPI/VCI key field within cell_in
KEY_LSB, 32, LSB of the key field; KEY_W = KEY_MSB-KEY_LSB+1 (16 by default)
N_ENTRIES, 8, table depth; IDX_W = clog2(N_ENTRIES), minimum 1
PORT_W, 2, output port ID width
DEFAULT_PORT, 0, port assigned on a miss
DROP_ON_MISS, 0, 1 = discard missed cells instead of forwarding them
CNT_W, 16, miss counter width

Ports:
clk  in  1  clock
rst  in  1  reset
cell_in  in  CELL_W  incoming cell
cell_valid  in  1  input valid
cell_ready  out  1  input ready
out_cell  out  CELL_W  registered copy of the accepted cell
out_port  out  PORT_W  routed port
out_hit  out  1  1 = table hit, 0 = default route
out_valid  out  1  output valid
out_ready  in  1  downstream ready
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  entry index
cfg_key  in  KEY_W  key to store
cfg_port  in  PORT_W  port to store
cfg_en  in  1  entry enable to store
miss_count  out  CNT_W  saturating miss count
miss_clr  in  1  synchronous clear of miss_count

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, all table entries are disabled (key/port cleared to 0). Outputs reset to: out_valid=0, out_cell=0, out_port=0, out_hit=0, miss_count=0.
- cell_ready = !out_valid || out_ready. This is combinational; it is low only while the held output is stalled.
- Accept: a cell is accepted when cell_valid && cell_ready.
- Lookup (combinational on cell_in): key = cell_in[KEY_MSB:KEY_LSB].
  - An entry hits when it is enabled and its stored key equals key.
  - If several entries hit, the lowest index wins.
  - No hit gives port = DEFAULT_PORT and hit = 0.
- Output register: on accept, out_cell, out_port and out_hit load on the next edge. Latency from accept to out_valid is 1 cycle.
- out_valid handling:
  - Set on an accept.
  - Cleared on (out_valid && out_ready) when there is no accept in the same cycle.
  - A simultaneous consume and accept keeps out_valid=1 and loads the new cell. This gives full throughput of 1 cell per cycle.
- Stall: while out_valid && !out_ready, out_cell, out_port and out_hit are held stable and cell_ready=0.
- DROP_ON_MISS=1: an accepted miss is consumed but does not load the output register.
  - out_valid follows the consume rule as if there were no accept.
  - The held output is never overwritten by a dropped cell.
- Miss counter:
  - Increments by 1 per accepted miss, in both drop modes.
  - Saturates at all-ones.
  - miss_clr takes priority over an increment in the same cycle; the result is 0.
- Table write:
  - When cfg_we=1, entry cfg_idx takes {cfg_key, cfg_port, cfg_en} at the edge.
  - A lookup in the same cycle uses the pre-write contents. The new entry applies from the next cycle.
  - If cfg_idx >= N_ENTRIES (non-power-of-2 depth), the write is ignored.
  - Writes are allowed at any time, including during stalls.
- Reset mid-operation: an in-flight output is discarded (out_valid=0) and the table is cleared. Software must reprogram the table after reset.

Test Plan:
1. Reset, program idx0 = {0x1001, port1, en}, send a cell with key 0x1001 and out_ready=1 -> out_valid=1 one cycle later, out_port=1, out_hit=1, out_cell equals the input.
2. Table empty, send key 0x2222 with DROP_ON_MISS=0 -> out_port=DEFAULT_PORT (0), out_hit=0, miss_count=1. Repeat with DROP_ON_MISS=1 -> out_valid stays 0, miss_count=1.
3. Program idx2 and idx5 both with key 0x1003 (ports 3 and 2), send 0x1003 -> out_port=3. Disable idx2 (cfg_en=0), resend -> out_port=2.
4. Backpressure: out_ready=0 with two cells offered -> first is held stable, cell_ready=0, second not accepted. Raise out_ready -> second appears next cycle. Back-to-back cells with out_ready=1 -> one output per cycle, no bubbles.
5. Write idx0 key 0x1004 to port 3 in the same cycle as a 0x1004 cell is accepted -> miss (hit=0, port 0). The next 0x1004 cell -> hit, port 3.
6. CNT_W=4, 16 misses -> miss_count=15 (saturated). miss_clr together with a miss -> 0. Assert rst while out_valid=1 -> out_valid=0 immediately and all entries miss afterwards.
